// File: rtl/morse_key_arbiter.sv
// Two-key arbiter for the shared morse datapath: grants one key per character,
// releases after a silence gap, alternates on ties and locks out a stuck key.
//   state   | meaning
//   IDLE    | no owner, waiting for a synchronised press
//   GRANT_A | key A owns the datapath, key_out follows A
//   GRANT_B | key B owns the datapath, key_out follows B
//   LOCK_A  | A held past the hold limit, wait for its release
//   LOCK_B  | B held past the hold limit, wait for its release
module morse_key_arbiter #(
  parameter int GAP_CYCLES      = 30_000_000,
  parameter int MAX_HOLD_CYCLES = 300_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_a_i,
  input  logic btn_b_i,
  output logic key_out_o,
  output logic grant_a_o,
  output logic grant_b_o,
  output logic char_done_o,
  output logic stuck_err_o
);

  localparam int MAX_T = (GAP_CYCLES > MAX_HOLD_CYCLES) ? GAP_CYCLES : MAX_HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_T);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_A = 3'd1,
    GRANT_B = 3'd2,
    LOCK_A  = 3'd3,
    LOCK_B  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q, key_d;
  logic          last_b_q, last_b_d;
  logic          done_q, done_d;
  logic          a_meta_q, a_s_q, b_meta_q, b_s_q;
  logic          own_s;
  logic [CW-1:0] cur;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_meta_q <= 1'b0;
      a_s_q    <= 1'b0;
      b_meta_q <= 1'b0;
      b_s_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      key_q    <= 1'b0;
      last_b_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      a_meta_q <= btn_a_i;
      a_s_q    <= a_meta_q;
      b_meta_q <= btn_b_i;
      b_s_q    <= b_meta_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      last_b_q <= last_b_d;
      done_q   <= done_d;
    end
  end

  // key_q holds the owner's level from the previous cycle, so a level change
  // restarts the run length; cur is the length of the run before this cycle.
  assign own_s = (state_q == GRANT_B) ? b_s_q : a_s_q;
  assign cur   = (own_s == key_q) ? cnt_q : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    key_d    = 1'b0;
    last_b_d = last_b_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_s_q && b_s_q) begin
          state_d = last_b_q ? GRANT_A : GRANT_B;
          key_d   = 1'b1;
        end else if (a_s_q) begin
          state_d = GRANT_A;
          key_d   = 1'b1;
        end else if (b_s_q) begin
          state_d = GRANT_B;
          key_d   = 1'b1;
        end
      end
      GRANT_A, GRANT_B: begin
        key_d = own_s;
        cnt_d = (cur == CNT_SAT) ? cur : cur + 1'b1;
        if (!own_s && cur == GAP_LAST) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          last_b_d = (state_q == GRANT_B);
          key_d    = 1'b0;
          cnt_d    = '0;
        end else if (own_s && cur == HOLD_LAST) begin
          state_d  = (state_q == GRANT_B) ? LOCK_B : LOCK_A;
          last_b_d = (state_q == GRANT_B);
          key_d    = 1'b0;
          cnt_d    = '0;
        end
      end
      LOCK_A: if (!a_s_q) state_d = IDLE;
      LOCK_B: if (!b_s_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign key_out_o   = key_q;
  assign grant_a_o   = (state_q == GRANT_A);
  assign grant_b_o   = (state_q == GRANT_B);
  assign char_done_o = done_q;
  assign stuck_err_o = (state_q == LOCK_A) || (state_q == LOCK_B);

endmodule

// File: tb/tb_morse_key_arbiter.sv
// Directed bench for morse_key_arbiter with GAP_CYCLES=8, MAX_HOLD_CYCLES=20.
// Output vector order in every check: {key_out, grant_a, grant_b, char_done, stuck_err}.
module tb_morse_key_arbiter;

  logic clk = 1'b0;
  logic rst, btn_a, btn_b;
  logic key_out, grant_a, grant_b, char_done, stuck_err;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  morse_key_arbiter #(.GAP_CYCLES(8), .MAX_HOLD_CYCLES(20)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .btn_a_i    (btn_a),
    .btn_b_i    (btn_b),
    .key_out_o  (key_out),
    .grant_a_o  (grant_a),
    .grant_b_o  (grant_b),
    .char_done_o(char_done),
    .stuck_err_o(stuck_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {key_out, grant_a, grant_b, char_done, stuck_err};
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tchk(input string tag, input logic [4:0] exp);
    tick();
    chk(tag, exp);
  endtask

  initial begin
    rst = 1'b1; btn_a = 1'b0; btn_b = 1'b0;
    // 1: reset and first grant, 3-cycle press-to-key latency
    tchk("rst_1", 5'b00000);
    tchk("rst_2", 5'b00000);
    rst = 1'b0;
    tchk("idle", 5'b00000);
    btn_a = 1'b1;
    tchk("t1_sync1", 5'b00000);
    tchk("t1_sync2", 5'b00000);
    tchk("t1_grant", 5'b11000);
    btn_a = 1'b0;
    tchk("t1_hold4", 5'b11000);
    tchk("t1_hold5", 5'b11000);
    tchk("t1_lag", 5'b01000);
    for (int i = 0; i < 6; i++) tchk("t1_gap", 5'b01000);
    tchk("t1_done", 5'b00010);
    tchk("t1_done_end", 5'b00000);

    // 2: 4-cycle press, single char_done 8 cycles after a_s falls
    btn_a = 1'b1;
    tchk("t2_sync1", 5'b00000);
    tchk("t2_sync2", 5'b00000);
    tchk("t2_grant", 5'b11000);
    tchk("t2_hold", 5'b11000);
    btn_a = 1'b0;
    for (int i = 5; i <= 13; i++) tchk("t2_gap", (i <= 6) ? 5'b11000 : 5'b01000);
    tchk("t2_done", 5'b00010);
    for (int i = 0; i < 3; i++) tchk("t2_quiet", 5'b00000);

    // 3: tie from reset goes to A, held B follows, next tie back to A
    rst = 1'b1;
    tchk("t3_rst", 5'b00000);
    rst = 1'b0; btn_a = 1'b1; btn_b = 1'b1;
    tchk("t3_sync1", 5'b00000);
    tchk("t3_sync2", 5'b00000);
    tchk("t3_tie_a", 5'b11000);
    btn_a = 1'b0;
    for (int i = 4; i <= 12; i++) tchk("t3_gap_a", (i <= 5) ? 5'b11000 : 5'b01000);
    tchk("t3_done_a", 5'b00010);
    tchk("t3_grant_b", 5'b10100);
    btn_b = 1'b0;
    tchk("t3_b15", 5'b10100);
    tchk("t3_b16", 5'b10100);
    tchk("t3_b_lag", 5'b00100);
    for (int i = 0; i < 6; i++) tchk("t3_gap_b", 5'b00100);
    tchk("t3_done_b", 5'b00010);
    btn_a = 1'b1; btn_b = 1'b1;
    tchk("t3_sync3", 5'b00000);
    tchk("t3_sync4", 5'b00000);
    tchk("t3_tie_a2", 5'b11000);

    // 4: rival toggling is ignored, key_out follows A only
    for (int i = 0; i < 6; i++) begin
      btn_b = ~btn_b;
      tchk("t4_rival", 5'b11000);
    end
    btn_b = 1'b1; btn_a = 1'b0;
    tchk("t4_a7", 5'b11000);
    tchk("t4_a8", 5'b11000);
    btn_a = 1'b1;
    tchk("t4_dip1", 5'b01000);
    tchk("t4_dip2", 5'b01000);
    tchk("t4_back", 5'b11000);
    btn_a = 1'b0; btn_b = 1'b0;
    tchk("t4_rel12", 5'b11000);
    tchk("t4_rel13", 5'b11000);
    for (int i = 0; i < 7; i++) tchk("t4_gap", 5'b01000);
    tchk("t4_done", 5'b00010);
    tchk("t4_idle", 5'b00000);

    // 5: stuck A locks out at count 19, B granted the cycle after lockout exit
    btn_a = 1'b1;
    tchk("t5_sync1", 5'b00000);
    tchk("t5_sync2", 5'b00000);
    for (int i = 0; i < 20; i++) tchk("t5_hold", 5'b11000);
    for (int i = 0; i < 3; i++) tchk("t5_lock", 5'b00001);
    btn_a = 1'b0; btn_b = 1'b1;
    tchk("t5_lock26", 5'b00001);
    tchk("t5_lock27", 5'b00001);
    tchk("t5_exit", 5'b00000);
    tchk("t5_grant_b", 5'b10100);
    btn_b = 1'b0;
    tchk("t5_b30", 5'b10100);
    tchk("t5_b31", 5'b10100);
    for (int i = 0; i < 7; i++) tchk("t5_gap_b", 5'b00100);
    tchk("t5_done_b", 5'b00010);

    // 6: reset mid-grant aborts without char_done, then A re-granted
    btn_a = 1'b1;
    tchk("t6_sync1", 5'b00000);
    tchk("t6_sync2", 5'b00000);
    tchk("t6_grant", 5'b11000);
    tchk("t6_hold4", 5'b11000);
    tchk("t6_hold5", 5'b11000);
    rst = 1'b1;
    tchk("t6_rst", 5'b00000);
    tchk("t6_rst2", 5'b00000);
    rst = 1'b0;
    tchk("t6_sync3", 5'b00000);
    tchk("t6_sync4", 5'b00000);
    tchk("t6_regrant", 5'b11000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
